mem_stream_reader: RTL and testbench



---
 rtl/mem_stream_reader.sv | 128 ++++++++++++
 tb/tb_mem_stream_reader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_reader.sv
// Drains a run of consecutive words from an asynchronous-read memory onto a valid/ready stream.
// Optional running checksum of delivered words: define MEM_STREAM_READER_CHECKSUM_EN.
module mem_stream_reader #(
   parameter int AW = 6,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          start,
   input  logic [AW-1:0] base,
   input  logic [AW:0]   len,
   output logic [AW-1:0] mem_a,
   input  logic [DW-1:0] mem_spo,
   output logic [DW-1:0] dout,
   output logic          dout_valid,
   input  logic          dout_ready,
   output logic          busy,
   output logic          done
`ifdef MEM_STREAM_READER_CHECKSUM_EN
   ,
   output logic [DW-1:0] checksum
`endif
);

   localparam int unsigned DEPTH = 2 ** AW;
   localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW:0]   remaining_q, remaining_d;
   logic [DW-1:0] dout_q, dout_d;
   logic          doutValid_q, doutValid_d;
   logic          done_q, done_d;
   logic          handshake;
   logic          loadSlot;

   assign handshake = doutValid_q & dout_ready;
   assign loadSlot  = ~doutValid_q | handshake;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         dout_q      <= '0;
         doutValid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         dout_q      <= dout_d;
         doutValid_q <= doutValid_d;
         done_q      <= done_d;
      end
   end

   // Reload whenever the output register is empty or being emptied; finish once the last word is taken.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      dout_d      = dout_q;
      doutValid_d = doutValid_q;
      done_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (len != '0) begin
                  addr_d      = base;
                  remaining_d = (len > DEPTH_W) ? DEPTH_W : len;
                  state_d     = RUN;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (loadSlot && (remaining_q != '0)) begin
               dout_d      = mem_spo;
               doutValid_d = 1'b1;
               addr_d      = addr_q + AW'(1);
               remaining_d = remaining_q - (AW + 1)'(1);
            end else if (handshake) begin
               doutValid_d = 1'b0;
               state_d     = IDLE;
               done_d      = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_a      = addr_q;
   assign dout       = dout_q;
   assign dout_valid = doutValid_q;
   assign busy       = (state_q == RUN);
   assign done       = done_q;

`ifdef MEM_STREAM_READER_CHECKSUM_EN
   logic [DW-1:0] checksum_q, checksum_d;

   always_comb begin
      checksum_d = checksum_q;
      if ((state_q == IDLE) && start) begin
         checksum_d = '0;
      end else if ((state_q == RUN) && handshake) begin
         checksum_d = checksum_q + dout_q;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         checksum_q <= '0;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
// Randomized bench for mem_stream_reader: expected words come from a queue built from the memory image.
// Checksum checks are compiled in with MEM_STREAM_READER_CHECKSUM_EN.
module tb_mem_stream_reader;

   localparam int AW = 6;
   localparam int DW = 16;
   localparam int DEPTH = 64;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base = '0;
   logic [AW:0]   len = '0;
   logic [AW-1:0] mem_a;
   logic [DW-1:0] mem_spo;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic          dout_ready = 1'b0;
   logic          busy;
   logic          done;
`ifdef MEM_STREAM_READER_CHECKSUM_EN
   logic [DW-1:0] checksum;
`endif

   logic [DW-1:0] mem [DEPTH];
   int checks = 0;
   int passes = 0;

   assign mem_spo = mem[mem_a];

   always #5 clk = ~clk;

   mem_stream_reader #(.AW(AW), .DW(DW)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .start      (start),
      .base       (base),
      .len        (len),
      .mem_a      (mem_a),
      .mem_spo    (mem_spo),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .busy       (busy),
      .done       (done)
`ifdef MEM_STREAM_READER_CHECKSUM_EN
      ,
      .checksum   (checksum)
`endif
   );

   // Single point of comparison: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " mem_a"}, 32'(mem_a), 0);
      checkOutput({tag, " dout"}, 32'(dout), 0);
      checkOutput({tag, " dout_valid"}, 32'(dout_valid), 0);
      checkOutput({tag, " busy"}, 32'(busy), 0);
      checkOutput({tag, " done"}, 32'(done), 0);
`ifdef MEM_STREAM_READER_CHECKSUM_EN
      checkOutput({tag, " checksum"}, 32'(checksum), 0);
`endif
   endtask

   // One transfer, entered and left one time unit after a rising edge.
   // mode 0: ready always 1, mode 1: ready pattern 1,0,0 repeating, mode 2: random ready.
   task automatic applyStimulus(input int b, input int l, input int mode, input bit noisyStart);
      logic [DW-1:0] expWords [$];
      logic [DW-1:0] heldVal;
      bit            held;
      int            n, got, cyc, firstValid, doneCyc;
`ifdef MEM_STREAM_READER_CHECKSUM_EN
      logic [DW-1:0] sum;
      sum = '0;
`endif
      n = (l > DEPTH) ? DEPTH : l;
      for (int i = 0; i < n; i++) begin
         expWords.push_back(mem[(b + i) % DEPTH]);
`ifdef MEM_STREAM_READER_CHECKSUM_EN
         sum = sum + mem[(b + i) % DEPTH];
`endif
      end
      start = 1'b1;
      base = b[AW-1:0];
      len = l[AW:0];
      dout_ready = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      base = AW'($urandom);
      len = (AW + 1)'($urandom);
      cyc = 1;
      got = 0;
      held = 1'b0;
      firstValid = -1;
      doneCyc = -1;
      while (cyc < 2000) begin
         case (mode)
            0: dout_ready = 1'b1;
            1: dout_ready = ((cyc - 1) % 3 == 0);
            default: dout_ready = 1'($urandom_range(0, 1));
         endcase
         start = (noisyStart && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (noisyStart) begin
            base = AW'($urandom);
            len = (AW + 1)'($urandom);
         end
         @(negedge clk);
         if (cyc == 1) checkOutput("busy after start", 32'(busy), 32'(n != 0));
         if (held) begin
            checkOutput("valid held", 32'(dout_valid), 1);
            checkOutput("data held", 32'(dout), 32'(heldVal));
         end
         held = 1'b0;
         if (n != 0) checkOutput("mem_a next", 32'(mem_a), 32'((b + got + int'(dout_valid)) % DEPTH));
         if (dout_valid) begin
            if (firstValid < 0) firstValid = cyc;
            if (dout_ready) begin
               if (got < n) checkOutput("word", 32'(dout), 32'(expWords[got]));
               else checkOutput("extra word", 32'(got), 32'(n));
               got++;
            end else begin
               held = 1'b1;
               heldVal = dout;
            end
         end
         if (done) begin
            doneCyc = cyc;
            break;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      start = 1'b0;
      if (doneCyc < 0) checkOutput("done timeout", 0, 1);
      checkOutput("word count", 32'(got), 32'(n));
      checkOutput("busy at done", 32'(busy), 0);
      checkOutput("valid at done", 32'(dout_valid), 0);
      if (mode == 0) begin
         checkOutput("done cycle", 32'(doneCyc), (n == 0) ? 32'd1 : 32'(n + 2));
         if (n != 0) checkOutput("first valid cycle", 32'(firstValid), 2);
         else checkOutput("no valid for len 0", 32'(firstValid), 32'hFFFF_FFFF);
      end
`ifdef MEM_STREAM_READER_CHECKSUM_EN
      checkOutput("checksum", 32'(checksum), 32'(sum));
`endif
      @(negedge clk);
      checkOutput("done one cycle", 32'(done), 0);
`ifdef MEM_STREAM_READER_CHECKSUM_EN
      checkOutput("checksum stable", 32'(checksum), 32'(sum));
`endif
      @(posedge clk);
      #1;
   endtask

   // Reset asserted after two handshakes of a six-word run must clear everything and suppress done.
   task automatic resetMidTransfer();
      int got, cyc;
      start = 1'b1;
      base = 6'd10;
      len = 7'd6;
      dout_ready = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      got = 0;
      cyc = 0;
      while (got < 2 && cyc < 20) begin
         @(negedge clk);
         if (dout_valid && dout_ready) got++;
         cyc++;
      end
      checkOutput("words before reset", 32'(got), 2);
      rstn = 1'b0;
      #1;
      checkResetValues("async reset");
      @(posedge clk);
      #1;
      rstn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("no done after reset", 32'(done), 0);
         checkOutput("idle after reset", 32'(busy), 0);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 16'h1000 + 16'(i);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkResetValues("reset");
      rstn = 1'b1;
      @(posedge clk);
      #1;

      applyStimulus(5, 4, 0, 1'b0);
      applyStimulus(62, 3, 0, 1'b0);
      applyStimulus(7, 5, 1, 1'b0);
      applyStimulus(0, 0, 0, 1'b0);
      applyStimulus(20, 100, 0, 1'b0);
      applyStimulus(9, 6, 2, 1'b1);
      resetMidTransfer();
      applyStimulus(3, 6, 0, 1'b0);

      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
         applyStimulus($urandom_range(0, DEPTH - 1), $urandom_range(0, 127),
                       $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      for (int i = 0; i < 8; i++) mem[30 + i] = 16'hFFFF;
      applyStimulus(30, 8, 0, 1'b0);

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
